// File: rtl/pixel_move_sched_pkg.sv
// Shared types and constants for the cursor-move scheduler and its auto-repeat helper.
// Screen widths default here unless the display params header already defined them.
`ifndef SCREEN_X_BITWIDTH
`define SCREEN_X_BITWIDTH 10
`endif
`ifndef SCREEN_Y_BITWIDTH
`define SCREEN_Y_BITWIDTH 9
`endif

package pixel_move_sched_pkg;

  localparam int XW    = `SCREEN_X_BITWIDTH + 1;
  localparam int YW    = `SCREEN_Y_BITWIDTH + 1;
  localparam int RPT_W = 24;

  localparam logic [1:0] DIR_XP = 2'd0;
  localparam logic [1:0] DIR_XN = 2'd1;
  localparam logic [1:0] DIR_YP = 2'd2;
  localparam logic [1:0] DIR_YN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  typedef struct packed {
    logic xi;
    logic xd;
    logic yi;
    logic yd;
  } step_t;

  function automatic step_t dir_to_step(input logic [1:0] dir);
    step_t s;
    s = '0;
    case (dir)
      DIR_XP:  s.xi = 1'b1;
      DIR_XN:  s.xd = 1'b1;
      DIR_YP:  s.yi = 1'b1;
      default: s.yd = 1'b1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pixel_move_sched_btn_autorepeat.sv
// Per-button request generator: one pulse on press, another after REPEAT_DELAY held
// cycles, then one every REPEAT_PERIOD cycles; the count restarts on release.
module btn_autorepeat
  import pixel_move_sched_pkg::*;
#(
  parameter logic [RPT_W-1:0] REPEAT_DELAY  = 24'd5_000_000,
  parameter logic [RPT_W-1:0] REPEAT_PERIOD = 24'd1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic req_o
);

  logic             btn_q;
  logic [RPT_W-1:0] cnt_q, cnt_d;
  logic             rpt_q, rpt_d;

  always_comb begin
    cnt_d = '0;
    rpt_d = 1'b0;
    req_o = 1'b0;
    if (btn_i && !btn_q) begin
      req_o = 1'b1;
    end else if (btn_i) begin
      cnt_d = cnt_q + 1'b1;
      rpt_d = rpt_q;
      if (cnt_d == (rpt_q ? REPEAT_PERIOD : REPEAT_DELAY)) begin
        req_o = 1'b1;
        cnt_d = '0;
        rpt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_q <= 1'b0;
      cnt_q <= '0;
      rpt_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
      cnt_q <= cnt_d;
      rpt_q <= rpt_d;
    end
  end

endmodule

// File: rtl/pixel_move_sched.sv
// Cursor-position owner arbitrating the shared moving_pixel datapath between the
// button pad and the host step port. Host port built only with MOVE_HOST_PORT_EN.
module pixel_move_sched
  import pixel_move_sched_pkg::*;
#(
  parameter int               X_MAX         = 639,
  parameter int               Y_MAX         = 479,
  parameter logic [RPT_W-1:0] REPEAT_DELAY  = 24'd5_000_000,
  parameter logic [RPT_W-1:0] REPEAT_PERIOD = 24'd1_000_000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    btn_i,
  input  logic          host_valid_i,
  output logic          host_ready_o,
  input  logic [1:0]    host_dir_i,
  input  logic [7:0]    host_steps_i,
  output logic          host_done_o,
  output logic          host_clipped_o,
  output logic          x_inc_o,
  output logic          x_dec_o,
  output logic          y_inc_o,
  output logic          y_dec_o,
  output logic [XW-1:0] x_coord_o,
  output logic [YW-1:0] y_coord_o,
  input  logic [XW-1:0] x_new_i,
  input  logic [YW-1:0] y_new_i,
  output logic          busy_o
);

  localparam logic [XW-1:0] XMAX_C = XW'(X_MAX);
  localparam logic [YW-1:0] YMAX_C = YW'(Y_MAX);

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  step_t         stb_q, stb_d;
  logic          tx_host_q, tx_host_d;
  logic          tx_clip_q, tx_clip_d;
  logic          rr_q, rr_d;
  logic [3:0]    pend_q, pend_d;
  logic          active_q, active_d;
  logic [1:0]    dir_q, dir_d;
  logic [7:0]    rem_q, rem_d;
  logic          done_q, done_d;
  logic          clip_q, clip_d;
  logic          alive_q;

  logic [3:0]    req_vec, lvl;
  logic          accept, host_req, btn_req, grant_host, grant_btn;
  step_t         btn_step, host_step;

  function automatic step_t clamp(input step_t s, input logic [XW-1:0] x,
                                  input logic [YW-1:0] y);
    step_t r;
    r    = s;
    r.xi = s.xi & (x < XMAX_C);
    r.xd = s.xd & (x != '0);
    r.yi = s.yi & (y < YMAX_C);
    r.yd = s.yd & (y != '0);
    return r;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    btn_autorepeat #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_rpt (
      .clock(clock),
      .reset(reset),
      .btn_i(btn_i[gi]),
      .req_o(req_vec[gi])
    );
  end

`ifdef MOVE_HOST_PORT_EN
  assign host_ready_o   = alive_q & (state_q == ST_IDLE) & ~active_q;
  assign accept         = host_valid_i & host_ready_o;
  assign host_done_o    = done_q;
  assign host_clipped_o = clip_q;
`else
  logic unused_host;
  assign unused_host    = ^{host_valid_i, done_q, clip_q, alive_q};
  assign host_ready_o   = 1'b0;
  assign accept         = 1'b0;
  assign host_done_o    = 1'b0;
  assign host_clipped_o = 1'b0;
`endif

  // A held opposite button (pending or still down) cancels that axis.
  always_comb begin
    lvl         = pend_q | btn_i;
    btn_step    = '0;
    btn_step.xi = pend_q[0] & ~lvl[1];
    btn_step.xd = pend_q[1] & ~lvl[0];
    btn_step.yi = pend_q[2] & ~lvl[3];
    btn_step.yd = pend_q[3] & ~lvl[2];
    host_step   = clamp(dir_to_step(active_q ? dir_q : host_dir_i), x_q, y_q);
  end

  always_comb begin
    host_req   = active_q | (accept & (host_steps_i != 8'd0));
    btn_req    = |pend_q;
    grant_host = 1'b0;
    grant_btn  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (host_req && btn_req) begin
        grant_host = rr_q;
        grant_btn  = ~rr_q;
      end else begin
        grant_host = host_req;
        grant_btn  = btn_req;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (grant_host || grant_btn) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q != ST_IDLE);
    x_inc_o = 1'b0;
    x_dec_o = 1'b0;
    y_inc_o = 1'b0;
    y_dec_o = 1'b0;
    if (state_q == ST_ISSUE) begin
      x_inc_o = stb_q.xi;
      x_dec_o = stb_q.xd;
      y_inc_o = stb_q.yi;
      y_dec_o = stb_q.yd;
    end
  end

  assign x_coord_o = x_q;
  assign y_coord_o = y_q;

  always_comb begin
    stb_d     = stb_q;
    tx_host_d = tx_host_q;
    tx_clip_d = tx_clip_q;
    rr_d      = rr_q;
    pend_d    = pend_q | req_vec;
    active_d  = active_q;
    dir_d     = dir_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    clip_d    = 1'b0;
    x_d       = x_q;
    y_d       = y_q;
    if (accept) begin
      dir_d    = host_dir_i;
      rem_d    = host_steps_i;
      active_d = (host_steps_i != 8'd0);
      done_d   = (host_steps_i == 8'd0);
    end
    if (grant_host) begin
      stb_d     = host_step;
      tx_host_d = 1'b1;
      tx_clip_d = (host_step == '0);
      rr_d      = 1'b0;
    end else if (grant_btn) begin
      stb_d     = clamp(btn_step, x_q, y_q);
      tx_host_d = 1'b0;
      tx_clip_d = 1'b0;
      rr_d      = 1'b1;
      pend_d    = req_vec;
    end
    // Only axes that actually stepped take the mover result.
    if (state_q == ST_CAPTURE) begin
      if (stb_q.xi || stb_q.xd) x_d = x_new_i;
      if (stb_q.yi || stb_q.yd) y_d = y_new_i;
      if (tx_host_q) begin
        if (tx_clip_q) begin
          done_d   = 1'b1;
          clip_d   = 1'b1;
          active_d = 1'b0;
          rem_d    = 8'd0;
        end else begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            done_d   = 1'b1;
            active_d = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      stb_q     <= '0;
      tx_host_q <= 1'b0;
      tx_clip_q <= 1'b0;
      rr_q      <= 1'b0;
      pend_q    <= '0;
      active_q  <= 1'b0;
      dir_q     <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      clip_q    <= 1'b0;
      alive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      stb_q     <= stb_d;
      tx_host_q <= tx_host_d;
      tx_clip_q <= tx_clip_d;
      rr_q      <= rr_d;
      pend_q    <= pend_d;
      active_q  <= active_d;
      dir_q     <= dir_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      clip_q    <= clip_d;
      alive_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_move_sched.sv
// Directed bench for pixel_move_sched with a registered moving_pixel model.
module tb_pixel_move_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  btn = 4'd0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [1:0]  host_dir = 2'd0;
  logic [7:0]  host_steps = 8'd0;
  logic        host_done, host_clipped;
  logic        x_inc, x_dec, y_inc, y_dec;
  logic [10:0] x_coord;
  logic [9:0]  y_coord;
  logic [10:0] x_new = '0;
  logic [9:0]  y_new = '0;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int n_xi = 0, n_xd = 0, n_yi = 0, n_yd = 0;

  pixel_move_sched #(
    .X_MAX(639), .Y_MAX(479),
    .REPEAT_DELAY(24'd20), .REPEAT_PERIOD(24'd10)
  ) dut (
    .clock(clock), .reset(reset), .btn_i(btn),
    .host_valid_i(host_valid), .host_ready_o(host_ready),
    .host_dir_i(host_dir), .host_steps_i(host_steps),
    .host_done_o(host_done), .host_clipped_o(host_clipped),
    .x_inc_o(x_inc), .x_dec_o(x_dec), .y_inc_o(y_inc), .y_dec_o(y_dec),
    .x_coord_o(x_coord), .y_coord_o(y_coord),
    .x_new_i(x_new), .y_new_i(y_new), .busy_o(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    x_new <= x_coord + 11'(x_inc) - 11'(x_dec);
    y_new <= y_coord + 10'(y_inc) - 10'(y_dec);
    if (x_inc) n_xi <= n_xi + 1;
    if (x_dec) n_xd <= n_xd + 1;
    if (y_inc) n_yi <= n_yi + 1;
    if (y_dec) n_yd <= n_yd + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    tick();
    btn = 4'd0;
    repeat (6) tick();
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    btn = b;
    repeat (n) tick();
    btn = 4'd0;
    repeat (6) tick();
  endtask

  // Bit i of each mask = signal level after edge i of the window.
  task automatic run_mask(input int n, output logic [31:0] mxi, output logic [31:0] mxd,
                          output logic [31:0] myi, output logic [31:0] myd,
                          output logic [31:0] mdn, output logic [31:0] mcl);
    mxi = '0; mxd = '0; myi = '0; myd = '0; mdn = '0; mcl = '0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i == 1) host_valid = 1'b0;
      mxi[i] = x_inc; mxd[i] = x_dec; myi[i] = y_inc; myd[i] = y_dec;
      mdn[i] = host_done; mcl[i] = host_done & host_clipped;
    end
  endtask

  task automatic host_cmd(input string tag, input logic [1:0] d, input logic [7:0] s,
                          input logic exp_clip);
    bit seen;
    seen = 1'b0;
    host_dir = d; host_steps = s; host_valid = 1'b1;
    for (int i = 1; i <= 1000 && !seen; i++) begin
      tick();
      if (i == 1) host_valid = 1'b0;
      if (host_done) begin
        seen = 1'b1;
        check({tag, "_clip"}, 32'(host_clipped), 32'(exp_clip));
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    tick();
  endtask

  logic [31:0] mxi, mxd, myi, myd, mdn, mcl;
  int b_xi, b_xd, b_yi, b_yd;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_x", 32'(x_coord), 0);
    check("rst_y", 32'(y_coord), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_strobes", 32'({x_inc, x_dec, y_inc, y_dec}), 0);
    check("rst_ready", 32'(host_ready), 0);
    check("rst_done", 32'({host_done, host_clipped}), 0);
    reset = 1'b1;
    tick();
`ifdef MOVE_HOST_PORT_EN
    check("ready_after_rst", 32'(host_ready), 1);
`else
    check("ready_after_rst", 32'(host_ready), 0);
`endif

    // Single right press: strobe two edges after the press edge, position one step later
    btn = 4'b0001;
    tick();
    btn = 4'd0;
    tick();
    check("press_xinc", 32'(x_inc), 1);
    check("press_busy", 32'(busy), 1);
    tick();
    check("press_xinc_off", 32'(x_inc), 0);
    tick();
    check("press_pos_x", 32'(x_coord), 1);
    check("press_idle", 32'(busy), 0);
    repeat (10) tick();
    check("press_one_step", 32'(n_xi), 1);

    // Hold down for 45 cycles: press, +20, +30, +40 -> four y_inc steps
    b_yi = n_yi;
    hold(4'b0100, 45);
    check("repeat_count", 32'(n_yi - b_yi), 4);
    check("repeat_pos_y", 32'(y_coord), 4);

    // Left twice from x=1: second step suppressed at 0
    b_xd = n_xd;
    press(4'b0010);
    press(4'b0010);
    check("left_bound_x", 32'(x_coord), 0);
    check("left_bound_cnt", 32'(n_xd - b_xd), 1);

    // Right+down together: one diagonal transaction
    btn = 4'b0101;
    tick();
    btn = 4'd0;
    tick();
    check("diag_strobes", 32'({x_inc, x_dec, y_inc, y_dec}), 32'b1010);
    repeat (6) tick();
    check("diag_pos", 32'({x_coord, y_coord}), 32'({11'd1, 10'd5}));
    press(4'b0001);
    press(4'b0001);
    check("right2_x", 32'(x_coord), 3);

    // All four held: both axes cancelled for the whole hold
    b_xi = n_xi; b_xd = n_xd; b_yi = n_yi; b_yd = n_yd;
    hold(4'b1111, 45);
    check("opp_no_strobes", 32'((n_xi - b_xi) + (n_xd - b_xd) + (n_yi - b_yi) + (n_yd - b_yd)), 0);
    check("opp_pos", 32'({x_coord, y_coord}), 32'({11'd3, 10'd5}));

`ifdef MOVE_HOST_PORT_EN
    // Host +y 5 steps: strobes every 3 cycles, done after final capture
    host_dir = 2'd2; host_steps = 8'd5; host_valid = 1'b1;
    run_mask(17, mxi, mxd, myi, myd, mdn, mcl);
    check("h5_yinc_mask", myi, 32'd9362);
    check("h5_other_mask", mxi | mxd | myd, 0);
    check("h5_done_mask", mdn, 32'd32768);
    check("h5_clip_mask", mcl, 0);
    check("h5_pos", 32'({x_coord, y_coord}), 32'({11'd3, 10'd10}));

    // Zero-step command: done next cycle, nothing issued
    host_dir = 2'd0; host_steps = 8'd0; host_valid = 1'b1;
    run_mask(3, mxi, mxd, myi, myd, mdn, mcl);
    check("h0_done_mask", mdn, 32'd2);
    check("h0_strobes", mxi | mxd | myi | myd | mcl, 0);

    // Walk to x=637, then +x 10 clips after 638, 639
    host_cmd("walk1", 2'd0, 8'd255, 1'b0);
    host_cmd("walk2", 2'd0, 8'd255, 1'b0);
    host_cmd("walk3", 2'd0, 8'd124, 1'b0);
    check("walk_x", 32'(x_coord), 637);
    host_dir = 2'd0; host_steps = 8'd10; host_valid = 1'b1;
    run_mask(12, mxi, mxd, myi, myd, mdn, mcl);
    check("clip_xi_mask", mxi, 32'd18);
    check("clip_done_mask", mdn, 32'd512);
    check("clip_flag_mask", mcl, 32'd512);
    check("clip_pos_x", 32'(x_coord), 639);

    // Contention: host -y 4 from y=2 against held left; round-robin interleaves
    host_cmd("down8", 2'd3, 8'd8, 1'b0);
    check("pre_cont_y", 32'(y_coord), 2);
    btn = 4'b0010;
    host_dir = 2'd3; host_steps = 8'd4; host_valid = 1'b1;
    run_mask(14, mxi, mxd, myi, myd, mdn, mcl);
    btn = 4'd0;
    repeat (8) tick();
    check("cont_yd_mask", myd, 32'd130);
    check("cont_xd_mask", mxd, 32'd16);
    check("cont_done_mask", mdn, 32'd4096);
    check("cont_clip_mask", mcl, 32'd4096);
    check("cont_pos", 32'({x_coord, y_coord}), 32'({11'd638, 10'd0}));

    // Reset during ISSUE of a 3-step command
    host_dir = 2'd0; host_steps = 8'd3; host_valid = 1'b1;
    tick();
    check("hrst_issue", 32'(x_inc), 1);
    check("hrst_ready_busy", 32'(host_ready), 0);
    reset = 1'b0; host_valid = 1'b0;
    #1;
    check("hrst_async_out", 32'({x_inc, busy, host_ready, host_done, host_clipped}), 0);
    check("hrst_async_pos", 32'({x_coord, y_coord}), 0);
    tick();
    reset = 1'b1;
    tick();
    check("hrst_ready", 32'(host_ready), 1);
    run_mask(10, mxi, mxd, myi, myd, mdn, mcl);
    check("hrst_quiet", mxi | mxd | myi | myd | mdn, 0);
    check("hrst_pos", 32'({x_coord, y_coord}), 0);
`else
    // Host port absent: requests are ignored
    host_dir = 2'd0; host_steps = 8'd3; host_valid = 1'b1;
    #1;
    check("nohost_ready", 32'(host_ready), 0);
    run_mask(10, mxi, mxd, myi, myd, mdn, mcl);
    check("nohost_quiet", mxi | mxd | myi | myd | mdn, 0);
    check("nohost_pos", 32'({x_coord, y_coord}), 32'({11'd3, 10'd5}));
`endif

    // Reset during a button step
    btn = 4'b0001;
    tick();
    btn = 4'd0;
    tick();
    check("brst_issue", 32'(x_inc), 1);
    reset = 1'b0;
    #1;
    check("brst_async", 32'({x_inc, busy, x_coord, y_coord}), 0);
    tick();
    reset = 1'b1;
    run_mask(8, mxi, mxd, myi, myd, mdn, mcl);
    check("brst_quiet", mxi | mxd | myi | myd | mdn, 0);
    check("brst_pos", 32'({x_coord, y_coord}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
